// File: rtl/switch_tgen.sv
// switch_tgen - per-port traffic generator for one input of the 4-port switch.
//
// Sends bursts of NPKT addressed words over the switch valid/ack transmit
// handshake, with GAP idle cycles between an acked word and the next valid.
// The destination is either fixed (dst_fix_i) or sweeps 0,1,2,3,0...
//
// Optional build macro: TGEN_LFSR_EN
//   defined   : dat_o = low DW bits of an 8-bit Fibonacci LFSR
//               (x^8+x^6+x^5+x^4+1), seeded 8'h01 and stepped once per transfer
//   undefined : dat_o = incrementing sequence counter (no LFSR logic)
//
// Ports:
//   clk_i        single clock, all logic on the rising edge
//   rst_i        synchronous active-high reset
//   start_i      pulse, starts a burst from IDLE
//   stop_i       ends the burst after the current word (or at once in GAP)
//   dst_sweep_i  1 = sweeping destination, 0 = fixed dst_fix_i
//   dst_fix_i    fixed destination port
//   adr_o/dat_o  destination address / data word to the switch
//   validtx_o    word valid; acktx_i accept from the switch
//   busy_o       high in SEND or GAP
//   done_o       one-cycle pulse after the final transfer of a burst
//   sent_cnt_o   words transferred since reset (wraps)
//   stall_cnt_o  SEND cycles without ack (saturates)
//   err_o        sticky flag: TIMEOUT consecutive unacked SEND cycles
//
// state   | meaning
// --------+-----------------------------------------------------
// IDLE    | no burst; waiting for start_i
// SEND    | validtx_o high, holding adr_o/dat_o until acked
// GAP     | idle spacing between an acked word and the next valid

module switch_tgen #(
  parameter int DW      = 4,
  parameter int NPKT    = 16,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          dst_sweep_i,
  input  logic [1:0]    dst_fix_i,
  output logic [1:0]    adr_o,
  output logic [DW-1:0] dat_o,
  output logic          validtx_o,
  input  logic          acktx_i,
  output logic          busy_o,
  output logic          done_o,
  output logic [7:0]    sent_cnt_o,
  output logic [7:0]    stall_cnt_o,
  output logic          err_o
);

  localparam int            BW       = (NPKT < 2) ? 1 : $clog2(NPKT + 1);
  localparam logic [BW-1:0] LAST_CNT = BW'((NPKT == 0) ? 0 : NPKT - 1);
  localparam logic [7:0]    GAP_LD   = 8'((GAP == 0) ? 0 : GAP - 1);
  localparam logic [7:0]    TO_LD    = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          done_nxt;
  logic          xfer;
  logic          last_word;
  logic [BW-1:0] burst_cnt;
  logic [7:0]    gap_cnt;
  logic [7:0]    wait_cnt;

`ifdef TGEN_LFSR_EN
  logic [7:0] lfsr;
  assign dat_o = lfsr[DW-1:0];
`else
  logic [DW-1:0] seq;
  assign dat_o = seq;
`endif

  // validtx_o is high exactly in SEND, so a transfer is SEND plus ack.
  assign xfer      = (state == ST_SEND) && acktx_i;
  assign last_word = stop_i || ((NPKT != 0) && (burst_cnt == LAST_CNT));

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start_i) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (xfer) begin
          if (last_word) begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end else if (GAP != 0) begin
            state_nxt = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (stop_i) begin
          state_nxt = ST_IDLE;
          done_nxt  = 1'b1;
        end else if (gap_cnt == 8'd0) begin
          state_nxt = ST_SEND;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      validtx_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      adr_o       <= 2'd0;
      sent_cnt_o  <= 8'd0;
      stall_cnt_o <= 8'd0;
      err_o       <= 1'b0;
      burst_cnt   <= '0;
      gap_cnt     <= 8'd0;
      wait_cnt    <= 8'd0;
`ifdef TGEN_LFSR_EN
      lfsr        <= 8'h01;
`else
      seq         <= '0;
`endif
    end else begin
      // Outputs follow the next state so they line up with the state register.
      validtx_o <= (state_nxt == ST_SEND);
      busy_o    <= (state_nxt != ST_IDLE);
      done_o    <= done_nxt;

      if ((state == ST_IDLE) && start_i) begin
        burst_cnt <= '0;
        adr_o     <= dst_sweep_i ? 2'd0 : dst_fix_i;
        wait_cnt  <= TO_LD;
      end

      if (xfer) begin
        sent_cnt_o <= sent_cnt_o + 8'd1;
        burst_cnt  <= burst_cnt + 1'b1;
        adr_o      <= dst_sweep_i ? adr_o + 2'd1 : dst_fix_i;
        wait_cnt   <= TO_LD;
        gap_cnt    <= GAP_LD;
`ifdef TGEN_LFSR_EN
        lfsr       <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
`else
        seq        <= seq + 1'b1;
`endif
      end else if (state == ST_SEND) begin
        if (stall_cnt_o != 8'hFF) stall_cnt_o <= stall_cnt_o + 8'd1;
        // wait_cnt counts down the unacked cycles; reaching 1 here means
        // this is the TIMEOUT-th consecutive stall.
        if (wait_cnt == 8'd1) err_o <= 1'b1;
        if (wait_cnt != 8'd0) wait_cnt <= wait_cnt - 8'd1;
      end

      if ((state == ST_GAP) && (gap_cnt != 8'd0)) gap_cnt <= gap_cnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_switch_tgen.sv
module tb_switch_tgen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start [3];
  logic       stop  [3];
  logic       sweep [3];
  logic       ack   [3];
  logic [1:0] fix   [3];
  logic [1:0] adr   [3];
  logic [3:0] dat   [3];
  logic       valid [3];
  logic       busy  [3];
  logic       done  [3];
  logic       err   [3];
  logic [7:0] sent  [3];
  logic [7:0] stall [3];

  // A: short bursts, back-to-back, short timeout
  switch_tgen #(.DW(4), .NPKT(4), .GAP(0), .TIMEOUT(8)) u_a (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .stop_i(stop[0]),
    .dst_sweep_i(sweep[0]), .dst_fix_i(fix[0]), .adr_o(adr[0]), .dat_o(dat[0]),
    .validtx_o(valid[0]), .acktx_i(ack[0]), .busy_o(busy[0]), .done_o(done[0]),
    .sent_cnt_o(sent[0]), .stall_cnt_o(stall[0]), .err_o(err[0]));

  // B: gapped bursts of 3
  switch_tgen #(.DW(4), .NPKT(3), .GAP(2), .TIMEOUT(64)) u_b (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .stop_i(stop[1]),
    .dst_sweep_i(sweep[1]), .dst_fix_i(fix[1]), .adr_o(adr[1]), .dat_o(dat[1]),
    .validtx_o(valid[1]), .acktx_i(ack[1]), .busy_o(busy[1]), .done_o(done[1]),
    .sent_cnt_o(sent[1]), .stall_cnt_o(stall[1]), .err_o(err[1]));

  // C: continuous until stop
  switch_tgen #(.DW(4), .NPKT(0), .GAP(0), .TIMEOUT(64)) u_c (
    .clk_i(clk), .rst_i(rst), .start_i(start[2]), .stop_i(stop[2]),
    .dst_sweep_i(sweep[2]), .dst_fix_i(fix[2]), .adr_o(adr[2]), .dat_o(dat[2]),
    .validtx_o(valid[2]), .acktx_i(ack[2]), .busy_o(busy[2]), .done_o(done[2]),
    .sent_cnt_o(sent[2]), .stall_cnt_o(stall[2]), .err_o(err[2]));

  typedef struct packed {
    logic [1:0] adr;
    logic [3:0] dat;
  } word_t;

  word_t       sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_done;
  logic [31:0] vhist;
  logic [7:0]  m_seq  [3];
  logic [7:0]  m_lfsr [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_seq[i]  = 8'h00;
      m_lfsr[i] = 8'h01;
    end
    sb_q.delete();
  endtask

  function automatic logic [3:0] mdat(input int i);
`ifdef TGEN_LFSR_EN
    return m_lfsr[i][3:0];
`else
    return m_seq[i][3:0];
`endif
  endfunction

  // Expected word for the next transfer of instance i; advances the data model.
  task automatic push(input int i, input logic [1:0] a);
    sb_q.push_back({a, mdat(i)});
    m_seq[i]  = m_seq[i] + 8'd1;
    m_lfsr[i] = {m_lfsr[i][6:0], m_lfsr[i][7] ^ m_lfsr[i][5] ^ m_lfsr[i][4] ^ m_lfsr[i][3]};
  endtask

  // One clock of instance i: record valid, score a transfer about to happen,
  // then advance to #1 after the edge and note any done pulse.
  task automatic step(input int i);
    word_t w;
    vhist = {vhist[30:0], valid[i]};
    if (valid[i] && ack[i]) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        w = sb_q.pop_front();
        chk("sb_adr", 32'(adr[i]), 32'(w.adr));
        chk("sb_dat", 32'(dat[i]), 32'(w.dat));
      end
    end
    @(posedge clk);
    #1;
    if (done[i]) n_done++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i] = 1'b0; stop[i] = 1'b0; sweep[i] = 1'b0; ack[i] = 1'b0; fix[i] = 2'd0;
    end
    model_reset();
    n_done = 0;
    vhist  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset values
    chk("rst_adr",   32'(adr[0]),   32'd0);
    chk("rst_dat",   32'(dat[0]),   32'(mdat(0)));
    chk("rst_valid", 32'(valid[0]), 32'd0);
    chk("rst_busy",  32'(busy[0]),  32'd0);
    chk("rst_done",  32'(done[0]),  32'd0);
    chk("rst_sent",  32'(sent[0]),  32'd0);
    chk("rst_stall", 32'(stall[0]), 32'd0);
    chk("rst_err",   32'(err[0]),   32'd0);

    // back-to-back sweeping burst of 4
    sweep[0] = 1'b1; ack[0] = 1'b1;
    for (int k = 0; k < 4; k++) push(0, 2'(k));
    start[0] = 1'b1; step(0); start[0] = 1'b0;
    chk("t1_valid_after_start", 32'(valid[0]), 32'd1);
    chk("t1_busy", 32'(busy[0]), 32'd1);
    n_done = 0; vhist = '0;
    repeat (6) step(0);
    chk("t1_valid_pattern", 32'(vhist[5:0]), 32'b111100);
    chk("t1_done_pulses", 32'(n_done), 32'd1);
    chk("t1_sent", 32'(sent[0]), 32'd4);
    chk("t1_sb_drained", 32'(sb_q.size()), 32'd0);

    // fixed destination, 5-cycle stall, single word ended by stop
    sweep[0] = 1'b0; fix[0] = 2'b10; ack[0] = 1'b0;
    push(0, 2'b10);
    start[0] = 1'b1; step(0); start[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("t3_adr_hold", 32'(adr[0]), 32'd2);
      chk("t3_dat_hold", 32'(dat[0]), 32'(sb_q[0].dat));
      chk("t3_valid_hold", 32'(valid[0]), 32'd1);
      step(0);
    end
    ack[0] = 1'b1; stop[0] = 1'b1; n_done = 0;
    step(0);
    ack[0] = 1'b0; stop[0] = 1'b0;
    chk("t3_stall", 32'(stall[0]), 32'd5);
    chk("t3_sent", 32'(sent[0]), 32'd5);
    chk("t3_idle", 32'(valid[0]), 32'd0);
    chk("t3_done", 32'(n_done), 32'd1);

    // timeout after 8 unacked SEND cycles
    fix[0] = 2'b01;
    push(0, 2'b01);
    start[0] = 1'b1; step(0); start[0] = 1'b0;
    repeat (7) step(0);
    chk("t4_err_before", 32'(err[0]), 32'd0);
    step(0);
    chk("t4_err_set", 32'(err[0]), 32'd1);
    chk("t4_valid_held", 32'(valid[0]), 32'd1);
    ack[0] = 1'b1; stop[0] = 1'b1;
    step(0);
    ack[0] = 1'b0; stop[0] = 1'b0;
    step(0);
    chk("t4_err_sticky", 32'(err[0]), 32'd1);
    chk("t4_stall", 32'(stall[0]), 32'd13);
    chk("t4_sent", 32'(sent[0]), 32'd6);
    chk("t4_idle", 32'(valid[0]), 32'd0);

    // GAP = 2, NPKT = 3
    sweep[1] = 1'b1; ack[1] = 1'b1;
    for (int k = 0; k < 3; k++) push(1, 2'(k));
    start[1] = 1'b1; step(1); start[1] = 1'b0;
    n_done = 0; vhist = '0;
    repeat (9) step(1);
    chk("t2_valid_pattern", 32'(vhist[8:0]), 32'b100100100);
    chk("t2_done_pulses", 32'(n_done), 32'd1);
    chk("t2_sent", 32'(sent[1]), 32'd3);
    chk("t2_busy_end", 32'(busy[1]), 32'd0);
    chk("t2_sb_drained", 32'(sb_q.size()), 32'd0);

    // NPKT = 0, stop raised mid-stall
    sweep[2] = 1'b0; fix[2] = 2'd3; ack[2] = 1'b0;
    push(2, 2'd3);
    start[2] = 1'b1; step(2); start[2] = 1'b0;
    repeat (3) step(2);
    stop[2] = 1'b1; n_done = 0;
    repeat (2) step(2);
    chk("t5_valid_under_stop", 32'(valid[2]), 32'd1);
    chk("t5_no_early_done", 32'(n_done), 32'd0);
    ack[2] = 1'b1;
    step(2);
    stop[2] = 1'b0; vhist = '0;
    repeat (4) step(2);
    chk("t5_no_more_valid", 32'(vhist[3:0]), 32'd0);
    chk("t5_done", 32'(n_done), 32'd1);
    chk("t5_sent", 32'(sent[2]), 32'd1);
    chk("t5_stall", 32'(stall[2]), 32'd5);
    chk("t5_sb_drained", 32'(sb_q.size()), 32'd0);

    // reset mid-burst, then a fresh burst from the reset data value
    sweep[2] = 1'b1; ack[2] = 1'b1;
    for (int k = 0; k < 5; k++) push(2, 2'(k));
    start[2] = 1'b1; step(2); start[2] = 1'b0;
    repeat (5) step(2);
    chk("t6_valid_mid", 32'(valid[2]), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    chk("t6_rst_valid", 32'(valid[2]), 32'd0);
    chk("t6_rst_busy", 32'(busy[2]), 32'd0);
    chk("t6_rst_sent", 32'(sent[2]), 32'd0);
    chk("t6_rst_stall", 32'(stall[2]), 32'd0);
    chk("t6_rst_dat", 32'(dat[2]), 32'(mdat(2)));
    chk("t6_rst_err_a", 32'(err[0]), 32'd0);
    chk("t6_rst_sent_a", 32'(sent[0]), 32'd0);
    for (int k = 0; k < 3; k++) push(2, 2'(k));
    start[2] = 1'b1; step(2); start[2] = 1'b0;
    step(2);
    step(2);
    stop[2] = 1'b1;
    step(2);
    stop[2] = 1'b0; ack[2] = 1'b0;
    step(2);
    chk("t6_idle", 32'(valid[2]), 32'd0);
    chk("t6_sent", 32'(sent[2]), 32'd3);
    chk("t6_sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/switch_tgen.md
# switch_tgen

Per-port traffic generator that drives one input port of the 4-port switch with addressed data words over the switch's valid/ack transmit handshake. One instance sits directly upstream of each switch input port, so the bench and FPGA build can run bursts without an external stimulus source. It sequences bursts of NPKT words with programmable inter-word gaps, fixed or sweeping destinations, and counters for transfers and stalled cycles.

## Interface
- DW, 4: data width; must match the switch DW; 1..8.
- NPKT, 16: words per burst; 0 = continuous until stop_i.
- GAP, 2: idle cycles between an acked word and the next valid; 0..255.
- TIMEOUT, 64: consecutive unacked SEND cycles before err_o sets; 1..255.

- clk_i  in  1  single clock; all logic rises on clk_i.
- rst_i  in  1  reset, synchronous, active-high.
- start_i  in  1  single-cycle pulse; starts a burst when in IDLE.
- stop_i  in  1  level or pulse; ends the burst after the current word.
- dst_sweep_i  in  1  1 = destination cycles 0,1,2,3,0…; 0 = fixed.
- dst_fix_i  in  2  fixed destination port when dst_sweep_i = 0.
- adr_o  out  2  destination address to switch adr_i.
- dat_o  out  DW  data word to switch dat_i.
- validtx_o  out  1  word valid to switch validtx.
- acktx_i  in  1  accept from switch acktx.
- busy_o  out  1  high in SEND or GAP.
- done_o  out  1  one-cycle pulse when a burst ends.
- sent_cnt_o  out  8  words transferred since reset, wraps 255→0.
- stall_cnt_o  out  8  SEND cycles with acktx_i low, saturates at 255.
- err_o  out  1  sticky timeout flag.

## Operation
- States: IDLE, SEND, GAP. Reset → IDLE.
- IDLE: validtx_o = 0. start_i = 1 → SEND; burst word count := 0; destination := dst_fix_i, or 0 if dst_sweep_i. start_i outside IDLE is ignored.
- SEND: validtx_o = 1; adr_o and dat_o held stable until transfer.
- Transfer: a rising edge with validtx_o = 1 and acktx_i = 1. On transfer: sent_cnt_o++, burst count++, advance data, and advance destination (sweep) or reload dst_fix_i.
- After transfer: if stop_i = 1, or NPKT ≠ 0 and burst count = NPKT → IDLE, done_o pulses. Else if GAP = 0, stay in SEND with the next word (back-to-back). Else → GAP.
- GAP: validtx_o = 0; counts GAP cycles, then → SEND. stop_i in GAP → IDLE with done_o.
- Valid is never withdrawn in SEND without a transfer. stop_i in SEND only takes effect on the transfer edge.
- acktx_i while validtx_o = 0 is ignored and counts nothing.
- Stall/timeout: each SEND cycle without ack increments stall_cnt_o (saturating) and a wait counter; the wait counter clears on transfer. Wait counter = TIMEOUT → err_o := 1 and stays set until reset. The FSM keeps holding valid.
- Default data: dat_o = low DW bits of a sequence counter. The counter is 0 after reset, increments per transfer, and persists across bursts.
- Reset mid-burst: all state clears the same cycle; validtx_o drops after the reset edge.

## Timing
- All outputs registered. Reset values: adr_o = 0, dat_o = 0, validtx_o = 0, busy_o = 0, done_o = 0, sent_cnt_o = 0, stall_cnt_o = 0, err_o = 0.
- start_i sampled at edge N → validtx_o = 1 after edge N.
- Transfer at edge M → after M, either the next word is valid (GAP = 0) or validtx_o = 0 for exactly GAP cycles.
- Sustained throughput with GAP = 0 and acktx_i tied high: one word per cycle.
- done_o is high for the single cycle after the final transfer edge.

## Configuration
- TGEN_LFSR_EN defined: dat_o = low DW bits of an 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1).
  - Seed 8'h01 at reset.
  - The LFSR steps once per transfer.
- TGEN_LFSR_EN undefined: dat_o = incrementing sequence counter. No LFSR logic is synthesized.

## Test plan
- Reset, then start_i pulse, NPKT = 4, GAP = 0, acktx_i tied 1, dst_sweep_i = 1 → 4 consecutive valid cycles with adr_o 0,1,2,3 and dat_o 0,1,2,3; done_o pulses once; sent_cnt_o = 4.
- GAP = 2, NPKT = 3, acktx_i = 1 → valid pattern 1,0,0,1,0,0,1, then idle; done_o pulses after the third word.
- dst_sweep_i = 0, dst_fix_i = 2'b10, acktx_i low for 5 cycles then high → adr_o/dat_o stable throughout the stall; stall_cnt_o = 5; single transfer.
- TIMEOUT = 8, acktx_i held 0 → err_o rises exactly 8 SEND cycles after valid; validtx_o stays 1; err_o stays set after acktx_i resumes.
- NPKT = 0, stop_i asserted mid-stall → word completes on ack, then IDLE with done_o; no further valid.
- TGEN_LFSR_EN defined, acktx_i = 1, DW = 4 → dat_o sequence is the low nibble of LFSR states starting at 4'h1. Assert rst_i mid-burst → validtx_o = 0 next cycle and all counters return to 0.
